// File: rtl/p_inside_pkg.sv
// Shared types for the hit-point inside test: default widths, coordinate
// vector type and the edge-walk state encoding.
package p_hit_pkg;

  localparam int DEFAULT_D_BITS = 32;
  localparam int DEFAULT_Q_BITS = 16;
  localparam int DEFAULT_M_BITS = 32;

  typedef logic signed [DEFAULT_D_BITS-1:0] vec3 [3];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E0   = 3'd1,
    E1   = 3'd2,
    E2   = 3'd3,
    EMIT = 3'd4,
    HOLD = 3'd5
  } state_e;

endpackage

// File: rtl/p_inside_edge_sign.sv
// Combinational edge test: sign of dot(cross(vb - va, p - va), n).
// Subtractions wrap at D_BITS; cross terms are shifted back to Q format.
module edge_sign #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 16
) (
  input  logic signed [D_BITS-1:0] va [3],
  input  logic signed [D_BITS-1:0] vb [3],
  input  logic signed [D_BITS-1:0] p  [3],
  input  logic signed [D_BITS-1:0] n  [3],
  output logic                     neg
);

  function automatic logic signed [2*D_BITS:0] ext_x(input logic signed [D_BITS-1:0] a);
    return $signed({{(D_BITS+1){a[D_BITS-1]}}, a});
  endfunction

  function automatic logic signed [2*D_BITS+1:0] ext_d(input logic signed [D_BITS-1:0] a);
    return $signed({{(D_BITS+2){a[D_BITS-1]}}, a});
  endfunction

  // a*b - c*d at full precision, then back to Q format and truncated
  function automatic logic signed [D_BITS-1:0] cross_term(
    input logic signed [D_BITS-1:0] a,
    input logic signed [D_BITS-1:0] b,
    input logic signed [D_BITS-1:0] c,
    input logic signed [D_BITS-1:0] d
  );
    logic signed [2*D_BITS:0] diff;
    diff = ext_x(a) * ext_x(b) - ext_x(c) * ext_x(d);
    diff = diff >>> Q_BITS;
    return diff[D_BITS-1:0];
  endfunction

  // Only the sign of the unshifted dot product matters
  function automatic logic dot_neg(
    input logic signed [D_BITS-1:0] x0, input logic signed [D_BITS-1:0] x1,
    input logic signed [D_BITS-1:0] x2, input logic signed [D_BITS-1:0] y0,
    input logic signed [D_BITS-1:0] y1, input logic signed [D_BITS-1:0] y2
  );
    logic signed [2*D_BITS+1:0] acc;
    acc = ext_d(x0) * ext_d(y0) + ext_d(x1) * ext_d(y1) + ext_d(x2) * ext_d(y2);
    return acc[2*D_BITS+1];
  endfunction

  logic signed [D_BITS-1:0] e_s  [3];
  logic signed [D_BITS-1:0] c_s  [3];
  logic signed [D_BITS-1:0] cr_s [3];

  // Edge vector, hit-point offset and their cross product
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      e_s[i] = vb[i] - va[i];
      c_s[i] = p[i] - va[i];
    end
    cr_s[0] = cross_term(e_s[1], c_s[2], e_s[2], c_s[1]);
    cr_s[1] = cross_term(e_s[2], c_s[0], e_s[0], c_s[2]);
    cr_s[2] = cross_term(e_s[0], c_s[1], e_s[1], c_s[0]);
  end

  assign neg = dot_neg(cr_s[0], cr_s[1], cr_s[2], n[0], n[1], n[2]);

endmodule

// File: rtl/p_inside.sv
// Three-edge inside/outside test on a popped hit point, walking one shared
// edge unit over E0..E2 and presenting a one-deep registered result.
module p_inside
  import p_hit_pkg::*;
#(
  parameter int D_BITS = DEFAULT_D_BITS,
  parameter int Q_BITS = DEFAULT_Q_BITS,
  parameter int M_BITS = DEFAULT_M_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [D_BITS-1:0] p_hit_in       [3],
  input  logic signed [D_BITS-1:0] v0_in          [3],
  input  logic signed [D_BITS-1:0] v1_in          [3],
  input  logic signed [D_BITS-1:0] v2_in          [3],
  input  logic signed [D_BITS-1:0] tri_normal_in  [3],
  input  logic        [M_BITS-1:0] triangle_id_in [3],
  input  logic                     in_empty,
  output logic                     in_rd_en,
  output logic                     hit,
  output logic signed [D_BITS-1:0] p_hit_out       [3],
  output logic        [M_BITS-1:0] triangle_id_out [3],
  output logic                     out_empty,
  input  logic                     out_rd_en
);

  state_e state_r, state_s;
  logic signed [D_BITS-1:0] p_r [3], v0_r [3], v1_r [3], v2_r [3], n_r [3];
  logic        [M_BITS-1:0] id_r [3];
  logic signed [D_BITS-1:0] va_s [3], vb_s [3];
  logic signed [D_BITS-1:0] p_out_r [3];
  logic        [M_BITS-1:0] id_out_r [3];
  logic [2:0] neg_r;
  logic       neg_s, pop_s, load_s, hit_r, out_empty_r;

  assign pop_s    = (state_r == IDLE) && !in_empty;
  assign in_rd_en = pop_s;

  // Select the edge endpoints for the current walk step
  always_comb begin
    va_s = v0_r;
    vb_s = v1_r;
    case (state_r)
      E1: begin
        va_s = v1_r;
        vb_s = v2_r;
      end
      E2: begin
        va_s = v2_r;
        vb_s = v0_r;
      end
      default: begin
        va_s = v0_r;
        vb_s = v1_r;
      end
    endcase
  end

  edge_sign #(.D_BITS(D_BITS), .Q_BITS(Q_BITS)) u_edge (
    .va (va_s),
    .vb (vb_s),
    .p  (p_r),
    .n  (n_r),
    .neg(neg_s)
  );

  // Next state and result-load decision
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) state_s = E0;
        else       state_s = IDLE;
      end
      E0: state_s = E1;
      E1: state_s = E2;
      E2: state_s = EMIT;
      EMIT: begin
        if (out_empty_r || out_rd_en) begin
          load_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (out_rd_en) begin
          load_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Capture the popped item for the duration of the edge walk
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        p_r[i]  <= {D_BITS{1'b0}};
        v0_r[i] <= {D_BITS{1'b0}};
        v1_r[i] <= {D_BITS{1'b0}};
        v2_r[i] <= {D_BITS{1'b0}};
        n_r[i]  <= {D_BITS{1'b0}};
        id_r[i] <= {M_BITS{1'b0}};
      end
    end else if (pop_s) begin
      p_r  <= p_hit_in;
      v0_r <= v0_in;
      v1_r <= v1_in;
      v2_r <= v2_in;
      n_r  <= tri_normal_in;
      id_r <= triangle_id_in;
    end
  end

  // One edge sign per walk step
  always_ff @(posedge clock) begin
    if (reset) begin
      neg_r <= 3'b000;
    end else begin
      case (state_r)
        E0:      neg_r[0] <= neg_s;
        E1:      neg_r[1] <= neg_s;
        E2:      neg_r[2] <= neg_s;
        default: neg_r    <= neg_r;
      endcase
    end
  end

  // Result slot: a load wins over a simultaneous consumer pop
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_r       <= 1'b0;
      out_empty_r <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        p_out_r[i]  <= {D_BITS{1'b0}};
        id_out_r[i] <= {M_BITS{1'b0}};
      end
    end else if (load_s) begin
      hit_r       <= ~|neg_r;
      p_out_r     <= p_r;
      id_out_r    <= id_r;
      out_empty_r <= 1'b0;
    end else if (out_rd_en && !out_empty_r) begin
      out_empty_r <= 1'b1;
    end
  end

  assign hit             = hit_r;
  assign p_hit_out       = p_out_r;
  assign triangle_id_out = id_out_r;
  assign out_empty       = out_empty_r;

endmodule

// File: tb/tb_p_inside.sv
// Randomized and directed bench for p_inside against an arithmetic reference
// model of the three-edge inside test, with an in-order result scoreboard.
module tb_p_inside;
  import p_hit_pkg::*;

  typedef logic signed [127:0] big_t;
  typedef struct packed { logic [2:0][31:0] p, v0, v1, v2, n, id; } item_t;
  typedef struct packed { logic hit; logic [2:0][31:0] p, id; } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  vec3 p_hit_in = '{default: 32'sd0};
  vec3 v0_in = '{default: 32'sd0};
  vec3 v1_in = '{default: 32'sd0};
  vec3 v2_in = '{default: 32'sd0};
  vec3 tri_normal_in = '{default: 32'sd0};
  vec3 p_hit_out;
  logic [31:0] triangle_id_in [3] = '{default: 32'd0};
  logic [31:0] triangle_id_out [3];
  logic in_empty = 1'b1;
  logic out_rd_en = 1'b0;
  logic in_rd_en, hit, out_empty;

  p_inside dut (
    .clock(clock), .reset(reset),
    .p_hit_in(p_hit_in), .v0_in(v0_in), .v1_in(v1_in), .v2_in(v2_in),
    .tri_normal_in(tri_normal_in), .triangle_id_in(triangle_id_in),
    .in_empty(in_empty), .in_rd_en(in_rd_en),
    .hit(hit), .p_hit_out(p_hit_out), .triangle_id_out(triangle_id_out),
    .out_empty(out_empty), .out_rd_en(out_rd_en)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0, last_pop = -1, pop_count = 0, n_results = 0, dut_hits = 0;
  logic [31:0] last_id = 32'd0;
  int pop_log[$];
  item_t in_q[$];
  exp_t exp_q[$];
  bit gate_in = 1'b0;
  int rd_mode = 0;  // 0 never, 1 always, 2 random, 3 whenever a result is held

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2:0][31:0] v3(input int x, input int y, input int z);
    return {z, y, x};
  endfunction

  function automatic int vtx(input item_t it, input int k, input int c);
    case (k)
      0:       return it.v0[c];
      1:       return it.v1[c];
      default: return it.v2[c];
    endcase
  endfunction

  // Point is inside (or on) the triangle iff no edge gives a negative dot
  function automatic logic model_hit(input item_t it);
    int e[3], q[3], cr[3];
    int a, b;
    big_t dot;
    logic any_neg;
    any_neg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        e[c] = vtx(it, (i + 1) % 3, c) - vtx(it, i, c);
        q[c] = int'(it.p[c]) - vtx(it, i, c);
      end
      for (int c = 0; c < 3; c++) begin
        a = (c + 1) % 3;
        b = (c + 2) % 3;
        cr[c] = int'((big_t'(e[a]) * big_t'(q[b]) - big_t'(e[b]) * big_t'(q[a])) >>> 16);
      end
      dot = 128'sd0;
      for (int c = 0; c < 3; c++) dot += big_t'(cr[c]) * big_t'(int'(it.n[c]));
      if (dot < 0) any_neg = 1'b1;
    end
    return !any_neg;
  endfunction

  function automatic exp_t expect_of(input item_t it);
    exp_t x;
    x.hit = model_hit(it);
    x.p   = it.p;
    x.id  = it.id;
    return x;
  endfunction

  function automatic item_t mk(input logic [2:0][31:0] p, input logic [2:0][31:0] a,
                               input logic [2:0][31:0] b, input logic [2:0][31:0] c,
                               input logic [2:0][31:0] n, input int id);
    item_t it;
    it.p = p; it.v0 = a; it.v1 = b; it.v2 = c; it.n = n;
    it.id = v3(id, id ^ 32'h5A5A_0000, ~id);
    return it;
  endfunction

  function automatic int rnd_coord();
    if ($urandom_range(0, 7) == 0) return int'($urandom);
    return int'($urandom_range(0, 32'h7FFFF)) - 32'sh40000;
  endfunction

  function automatic item_t rand_item(input int id);
    logic [2:0][31:0] p, a, b, c, n;
    for (int k = 0; k < 3; k++) begin
      p[k] = rnd_coord(); a[k] = rnd_coord(); b[k] = rnd_coord();
      c[k] = rnd_coord(); n[k] = rnd_coord();
    end
    if ($urandom_range(0, 15) == 0) n = v3(0, 0, 0);
    return mk(p, a, b, c, n, id);
  endfunction

  // Present the head of the input queue as a show-ahead FIFO, and the consumer
  always @(posedge clock) begin
    #2;
    in_empty = gate_in || (in_q.size() == 0);
    if (in_q.size() > 0) begin
      for (int c = 0; c < 3; c++) begin
        p_hit_in[c]       = in_q[0].p[c];
        v0_in[c]          = in_q[0].v0[c];
        v1_in[c]          = in_q[0].v1[c];
        v2_in[c]          = in_q[0].v2[c];
        tri_normal_in[c]  = in_q[0].n[c];
        triangle_id_in[c] = in_q[0].id[c];
      end
    end
    case (rd_mode)
      1:       out_rd_en = 1'b1;
      2:       out_rd_en = ($urandom_range(0, 1) == 1);
      3:       out_rd_en = !out_empty;
      default: out_rd_en = 1'b0;
    endcase
  end

  // Compare every held result against the scoreboard, then apply this cycle's events
  always @(negedge clock) begin
    item_t it;
    if (!out_empty) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 128'd1, 128'd0);
      end else begin
        chk("res_hit", hit, exp_q[0].hit);
        chk("res_p", {p_hit_out[2], p_hit_out[1], p_hit_out[0]}, exp_q[0].p);
        chk("res_id", {triangle_id_out[2], triangle_id_out[1], triangle_id_out[0]}, exp_q[0].id);
      end
    end
    if (in_empty && in_rd_en) chk("rd_while_empty", 128'd1, 128'd0);
    if (out_rd_en && !out_empty && !reset && exp_q.size() > 0) begin
      last_id = exp_q[0].id[0];
      if (hit) dut_hits++;
      exp_q.delete(0);
      n_results++;
    end
    if (in_rd_en && in_q.size() > 0) begin
      it = in_q.pop_front();
      if (!reset) begin
        exp_q.push_back(expect_of(it));
        pop_count++;
        pop_log.push_back(cyc);
        if (last_pop >= 0) begin
          checks++;
          if (cyc - last_pop < 5) begin
            failures++;
            $display("FAIL pop_spacing: got %0d cycles expected at least 5", cyc - last_pop);
          end
        end
        last_pop = cyc;
      end
    end
    if (reset) begin
      exp_q.delete();
      last_pop = -1;
    end
  end

  task automatic wait_pop(input int max);
    int k = 0;
    @(negedge clock);
    while (!in_rd_en && k < max) begin
      @(negedge clock);
      k++;
    end
    chk("pop_timeout", in_rd_en, 1'b1);
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < max) begin
      @(negedge clock);
      k++;
    end
    chk("drain", 128'(in_q.size() + exp_q.size()), 128'd0);
  endtask

  localparam int ONE = 32'sh10000;

  initial begin
    item_t it;
    int base;
    logic [2:0][31:0] o, ex, ey, ez, nz, nneg;
    o = v3(0, 0, 0); ex = v3(ONE, 0, 0); ey = v3(0, ONE, 0);
    nz = v3(0, 0, ONE); nneg = v3(0, 0, -ONE);

    // Model pinned to hand-worked cases
    chk("model_inside", model_hit(mk(v3(32'sh4000, 32'sh4000, 0), o, ex, ey, nz, 1)), 1'b1);
    chk("model_outside", model_hit(mk(v3(ONE, ONE, 0), o, ex, ey, nz, 1)), 1'b0);
    chk("model_on_edge", model_hit(mk(v3(32'sh8000, 0, 0), o, ex, ey, nz, 1)), 1'b1);
    chk("model_wind", model_hit(mk(v3(32'sh4000, 32'sh4000, 0), o, ey, ex, nz, 1)), 1'b0);
    chk("model_wind_flip", model_hit(mk(v3(32'sh4000, 32'sh4000, 0), o, ey, ex, nneg, 1)), 1'b1);

    repeat (3) @(negedge clock);
    chk("rst_out_empty", out_empty, 1'b1);
    chk("rst_hit", hit, 1'b0);
    chk("rst_in_rd_en", in_rd_en, 1'b0);
    chk("rst_p_out", {p_hit_out[2], p_hit_out[1], p_hit_out[0]}, 96'd0);
    chk("rst_id_out", {triangle_id_out[2], triangle_id_out[1], triangle_id_out[0]}, 96'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Latency: pop at T, result visible at T+5
    in_q.push_back(mk(v3(32'sh4000, 32'sh4000, 0), o, ex, ey, nz, 7));
    wait_pop(20);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("lat_empty", out_empty, 1'b1);
      if (k == 1) chk("single_pulse", in_rd_en, 1'b0);
    end
    @(negedge clock);
    chk("lat_t5", out_empty, 1'b0);
    chk("t1_hit", hit, 1'b1);
    chk("t1_id", triangle_id_out[0], 32'd7);
    chk("t1_p", {p_hit_out[1], p_hit_out[0]}, {32'h4000, 32'h4000});

    rd_mode = 3;
    in_q.push_back(mk(v3(ONE, ONE, 0), o, ex, ey, nz, 8));
    in_q.push_back(mk(v3(32'sh8000, 0, 0), o, ex, ey, nz, 9));
    in_q.push_back(mk(v3(32'sh4000, 32'sh4000, 0), o, ey, ex, nz, 10));
    in_q.push_back(mk(v3(32'sh4000, 32'sh4000, 0), o, ey, ex, nneg, 11));
    wait_drain(200);

    // Stalled consumer: two pops, first result held stable, third stays queued
    @(posedge clock); #1 rd_mode = 0;
    pop_count = 0;
    base = n_results;
    for (int k = 0; k < 3; k++) in_q.push_back(mk(v3(32'sh2000, 32'sh2000, 0), o, ex, ey, nz, 100 + k));
    repeat (20) @(negedge clock);
    chk("stall_pops", pop_count, 2);
    chk("stall_id", triangle_id_out[0], 32'd100);
    chk("stall_held", out_empty, 1'b0);
    rd_mode = 3;
    wait_drain(200);
    chk("stall_count", n_results - base, 3);
    chk("stall_last", last_id, 32'd102);

    // Reset during E1 drops the in-flight item
    base = n_results;
    in_q.push_back(mk(v3(32'sh1000, 32'sh1000, 0), o, ex, ey, nz, 200));
    in_q.push_back(mk(v3(32'sh1000, 32'sh1000, 0), o, ex, ey, nz, 201));
    wait_pop(20);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1; gate_in = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_out_empty", out_empty, 1'b1);
    chk("abort_in_rd_en", in_rd_en, 1'b0);
    gate_in = 1'b0;
    wait_drain(200);
    chk("abort_count", n_results - base, 1);
    chk("abort_last", last_id, 32'd201);

    // Back-to-back stream with the consumer always ready
    @(posedge clock); #1 rd_mode = 1;
    repeat (3) @(negedge clock);
    pop_log.delete();
    base = n_results;
    dut_hits = 0;
    in_q.push_back(mk(v3(32'sh2000, 32'sh2000, 0), o, ex, ey, nz, 300));
    in_q.push_back(mk(v3(32'sh4000, 32'sh1000, 0), o, ex, ey, nz, 301));
    in_q.push_back(mk(v3(32'sh1000, 32'sh4000, 0), o, ex, ey, nz, 302));
    in_q.push_back(mk(v3(32'sh3000, 32'sh3000, 0), o, ex, ey, nz, 303));
    wait_drain(200);
    repeat (2) @(negedge clock);
    chk("stream_pops", pop_log.size(), 4);
    for (int k = 1; k < pop_log.size(); k++) chk("stream_gap", pop_log[k] - pop_log[k-1], 5);
    chk("stream_results", n_results - base, 4);
    chk("stream_hits", dut_hits, 4);

    // Random traffic with a random consumer
    rd_mode = 2;
    for (int k = 0; k < 200; k++) begin
      in_q.push_back(rand_item(1000 + k));
      repeat ($urandom_range(0, 6)) @(negedge clock);
    end
    wait_drain(5000);
    rd_mode = 3;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
